// File: rtl/uart_tx_engine.sv
// uart_tx_engine: drains the TX FIFO into start/LSB-first data/stop UART frames on txd_o.
// Define UART_TX_PARITY_EN to insert an even parity bit after the data bits.
module uart_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  output logic                  tx_fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] tx_fifo_rdata_i,
  input  logic                  tx_fifo_empty_i,
  output logic                  txd_o,
  output logic                  tx_busy_o
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
`endif
  state_t                state;
  logic [DIV_WIDTH-1:0]  div_m1;
  logic [DIV_WIDTH-1:0]  baud_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  parity;
`endif
  assign bit_end = baud_cnt == '0;
  // The pop is issued in the same IDLE cycle that sees data, so FIFO data lands during FETCH
  assign tx_fifo_rd_en_o = !rst && state == IDLE && !tx_fifo_empty_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      div_m1    <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      txd_o     <= 1'b1;
      tx_busy_o <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      if (state != IDLE && state != FETCH)
        baud_cnt <= bit_end ? div_m1 : baud_cnt - DIV_WIDTH'(1);
      case (state)
        IDLE:
          if (!tx_fifo_empty_i) begin
            div_m1    <= (baud_div_i == '0) ? '0 : baud_div_i - DIV_WIDTH'(1);
            tx_busy_o <= 1'b1;
            state     <= FETCH;
          end
        FETCH: begin
          shift    <= tx_fifo_rdata_i;
`ifdef UART_TX_PARITY_EN
          parity   <= ^tx_fifo_rdata_i;
`endif
          baud_cnt <= div_m1;
          txd_o    <= 1'b0;
          state    <= START;
        end
        START:
          if (bit_end) begin
            txd_o <= shift[0];
            state <= DATA;
          end
        DATA:
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              txd_o   <= parity;
              state   <= PARITY;
`else
              txd_o   <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              txd_o   <= shift[1];
            end
          end
`ifdef UART_TX_PARITY_EN
        PARITY:
          if (bit_end) begin
            txd_o <= 1'b1;
            state <= STOP;
          end
`endif
        STOP:
          if (bit_end) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt   <= '0;
              tx_busy_o <= 1'b0;
              state     <= IDLE;
            end else
              bit_cnt <= bit_cnt + BW'(1);
          end
        default: state <= IDLE;
      endcase
    end
endmodule
